int_op_decode_pipe: RTL

INT_OP_DECODE_PIPE -- requirements
Module: int_op_decode_pipe

---
 rtl/int_op_decode_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/int_op_decode_pipe.sv
// Integer-op decoder for a bundle of LANES instructions. Each lane is classified
// into one of ADD, SHIFT, BIT, MUL or DIV and marked illegal if it cannot be
// decoded. The bundle is held in a two-entry skid buffer (main and skid), and
// a saturating counter tracks accepted illegal lanes.
module int_op_decode_pipe #(
    parameter int LANES = 2,
    parameter int M_EXT = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES-1:0]     in_lane_vld,
    input  logic [7*LANES-1:0]   in_op,
    input  logic [3*LANES-1:0]   in_funct3,
    input  logic [7*LANES-1:0]   in_funct7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_lane_vld,
    output logic [5*LANES-1:0]   out_cls,
    output logic [LANES-1:0]     out_add_op,
    output logic [5*LANES-1:0]   out_bit_op,
    output logic [3*LANES-1:0]   out_shift_op,
    output logic [3*LANES-1:0]   out_md_op,
    output logic [LANES-1:0]     out_illegal,
    output logic [CNT_W-1:0]     illegal_cnt
);

    // cls = {DIV,MUL,BIT,SHIFT,ADD}, bit_op = {SLT,SUB,XOR,OR,AND}, shift_op = {SRA,SRL,SLL}
    typedef struct packed {
        logic [4:0] cls;
        logic       add_op;
        logic [4:0] bit_op;
        logic [2:0] shift_op;
        logic [2:0] md_op;
        logic       illegal;
    } lane_dec_t;

    function automatic lane_dec_t decode_lane(
        input logic       vld,
        input logic [6:0] op,
        input logic [2:0] f3,
        input logic [6:0] f7
    );
        lane_dec_t d;
        logic is_opimm, is_op, is_lui, is_auipc, is_m;
        logic bad, ok, is_add, is_shift, is_bit;
        d        = '0;
        is_opimm = (op == 7'b0010011);
        is_op    = (op == 7'b0110011);
        is_lui   = (op == 7'b0110111);
        is_auipc = (op == 7'b0010111);
        is_m     = is_op && (f7 == 7'b0000001) && (M_EXT != 0);
        // For OP-IMM the funct7 bits are immediate bits, only shifts constrain them.
        bad = !(is_opimm || is_op || is_lui || is_auipc)
            || (is_op && !((f7 == 7'b0000000) || (f7 == 7'b0100000) || is_m))
            || (is_op && (f7 == 7'b0100000) && !((f3 == 3'b000) || (f3 == 3'b101)))
            || (is_opimm && (f3 == 3'b001) && (f7 != 7'b0000000))
            || (is_opimm && (f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
        ok       = vld && !bad;
        is_add   = op[2] || ((f3 == 3'b000) && (is_opimm || (is_op && !f7[5] && !is_m)));
        is_shift = (f3[1:0] == 2'b01) && !op[2] && !is_m;
        is_bit   = !is_add && !is_shift && !is_m;
        d.illegal = vld && bad;
        if (ok) begin
            d.cls      = {is_m & f3[2], is_m & ~f3[2], is_bit, is_shift, is_add};
            d.add_op   = is_add && op[2] && !op[5];
            d.bit_op   = is_bit ? {f3[2:1] == 2'b01, f3 == 3'b000, f3 == 3'b100,
                                   f3 == 3'b110, f3 == 3'b111} : 5'b00000;
            d.shift_op = is_shift ? {f3[2] & f7[5], f3[2] & ~f7[5], ~f3[2]} : 3'b000;
            d.md_op    = is_m ? f3 : 3'b000;
        end
        return d;
    endfunction

    lane_dec_t [LANES-1:0] in_dec;
    logic [2:0]            in_ill_pop;

    lane_dec_t [LANES-1:0] main_dec, skid_dec;
    logic [LANES-1:0]      main_vld, skid_vld;
    logic                  main_full, skid_full;
    logic                  main_full_nxt, skid_full_nxt;
    logic                  ld_main_in, ld_main_skid, ld_skid;
    logic                  accept, drain;

    logic [CNT_W+2:0]      cnt_sum;
    logic [CNT_W-1:0]      cnt_sat;

    // Decode every lane of the incoming bundle and count its illegal lanes.
    always_comb begin
        in_dec     = '0;
        in_ill_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            in_dec[i]  = decode_lane(in_lane_vld[i], in_op[7*i +: 7],
                                     in_funct3[3*i +: 3], in_funct7[7*i +: 7]);
            in_ill_pop = in_ill_pop + {2'b00, in_dec[i].illegal};
        end
    end

    assign accept = in_valid && in_ready && !flush;
    assign drain  = main_full && out_ready;

    // Skid-buffer occupancy and load selection; flush wins over everything.
    always_comb begin
        main_full_nxt = main_full;
        skid_full_nxt = skid_full;
        ld_main_in    = 1'b0;
        ld_main_skid  = 1'b0;
        ld_skid       = 1'b0;
        if (flush) begin
            main_full_nxt = 1'b0;
            skid_full_nxt = 1'b0;
        end else if (!main_full) begin
            if (accept) begin
                ld_main_in    = 1'b1;
                main_full_nxt = 1'b1;
            end
        end else if (drain) begin
            if (skid_full) begin
                ld_main_skid  = 1'b1;
                skid_full_nxt = 1'b0;
            end else if (accept) begin
                ld_main_in    = 1'b1;
            end else begin
                main_full_nxt = 1'b0;
            end
        end else if (accept) begin
            ld_skid       = 1'b1;
            skid_full_nxt = 1'b1;
        end
    end

    // Occupancy flags; in_ready stays low through reset until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_full <= 1'b0;
            skid_full <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            main_full <= main_full_nxt;
            skid_full <= skid_full_nxt;
            in_ready  <= !skid_full_nxt;
        end
    end

    // Entry payloads: main loads from input or skid, skid loads from input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_dec <= '0;
            main_vld <= '0;
            skid_dec <= '0;
            skid_vld <= '0;
        end else begin
            if (ld_main_in) begin
                main_dec <= in_dec;
                main_vld <= in_lane_vld;
            end else if (ld_main_skid) begin
                main_dec <= skid_dec;
                main_vld <= skid_vld;
            end
            if (ld_skid) begin
                skid_dec <= in_dec;
                skid_vld <= in_lane_vld;
            end
        end
    end

    assign cnt_sum = {3'b000, illegal_cnt} + {{CNT_W{1'b0}}, in_ill_pop};
    assign cnt_sat = (cnt_sum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    // Illegal-lane counter, survives flush, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept) begin
            illegal_cnt <= cnt_sat;
        end
    end

    assign out_valid    = main_full;
    assign out_lane_vld = main_vld;

    // Unpack the main entry onto the per-lane output fields.
    always_comb begin
        out_cls      = '0;
        out_add_op   = '0;
        out_bit_op   = '0;
        out_shift_op = '0;
        out_md_op    = '0;
        out_illegal  = '0;
        for (int i = 0; i < LANES; i++) begin
            out_cls[5*i +: 5]      = main_dec[i].cls;
            out_add_op[i]          = main_dec[i].add_op;
            out_bit_op[5*i +: 5]   = main_dec[i].bit_op;
            out_shift_op[3*i +: 3] = main_dec[i].shift_op;
            out_md_op[3*i +: 3]    = main_dec[i].md_op;
            out_illegal[i]         = main_dec[i].illegal;
        end
    end

endmodule
